// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - AXI4-Lite master with a single-outstanding request/response port
// One transaction in flight: the request is latched, driven on AXI, and the result is held until consumed.
`timescale 1ns/1ps
module axi4_lite_master #(
  parameter int         ADDR_BITS = 32,
  parameter int         DATA_BITS = 64,
  parameter logic [2:0] PROT      = 3'b000,
  localparam int        STRB_BITS = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  input  logic [STRB_BITS-1:0] req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic                 err_sticky,
  output logic                 m_axi4lite_aw_valid,
  input  logic                 m_axi4lite_aw_ready,
  output logic [ADDR_BITS-1:0] m_axi4lite_aw_addr,
  output logic [2:0]           m_axi4lite_aw_prot,
  output logic                 m_axi4lite_w_valid,
  input  logic                 m_axi4lite_w_ready,
  output logic [DATA_BITS-1:0] m_axi4lite_w_data,
  output logic [STRB_BITS-1:0] m_axi4lite_w_strb,
  input  logic                 m_axi4lite_b_valid,
  output logic                 m_axi4lite_b_ready,
  input  logic [1:0]           m_axi4lite_b_resp,
  output logic                 m_axi4lite_ar_valid,
  input  logic                 m_axi4lite_ar_ready,
  output logic [ADDR_BITS-1:0] m_axi4lite_ar_addr,
  output logic [2:0]           m_axi4lite_ar_prot,
  input  logic                 m_axi4lite_r_valid,
  output logic                 m_axi4lite_r_ready,
  input  logic [DATA_BITS-1:0] m_axi4lite_r_data,
  input  logic [1:0]           m_axi4lite_r_resp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;
  logic                 write_q;
  logic                 aw_sent_q, aw_sent_d;
  logic                 w_sent_q, w_sent_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [1:0]           resp_q, resp_d;
  logic                 rsp_write_q, rsp_write_d;
  logic                 err_q, err_d;
  logic                 req_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

  // req_ready is gated by rstn so nothing can be accepted while reset is held.
  assign req_ready = rstn && (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;

  assign m_axi4lite_aw_valid = (state_q == WR_REQ) && !aw_sent_q;
  assign m_axi4lite_w_valid  = (state_q == WR_REQ) && !w_sent_q;
  assign m_axi4lite_b_ready  = (state_q == WR_RESP);
  assign m_axi4lite_ar_valid = (state_q == RD_REQ);
  assign m_axi4lite_r_ready  = (state_q == RD_RESP);
  assign m_axi4lite_aw_addr  = addr_q;
  assign m_axi4lite_ar_addr  = addr_q;
  assign m_axi4lite_aw_prot  = PROT;
  assign m_axi4lite_ar_prot  = PROT;
  assign m_axi4lite_w_data   = wdata_q;
  assign m_axi4lite_w_strb   = wstrb_q;

  assign aw_fire = m_axi4lite_aw_valid && m_axi4lite_aw_ready;
  assign w_fire  = m_axi4lite_w_valid && m_axi4lite_w_ready;
  assign b_fire  = m_axi4lite_b_valid && m_axi4lite_b_ready;
  assign ar_fire = m_axi4lite_ar_valid && m_axi4lite_ar_ready;
  assign r_fire  = m_axi4lite_r_valid && m_axi4lite_r_ready;

  assign rsp_valid  = (state_q == RSP);
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_resp   = resp_q;
  assign err_sticky = err_q;

  always_comb begin
    state_d     = state_q;
    aw_sent_d   = aw_sent_q;
    w_sent_d    = w_sent_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    rsp_write_d = rsp_write_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d   = req_write ? WR_REQ : RD_REQ;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
        end
      end
      WR_REQ: begin
        // aw and w may complete in either order or together; leave once both are done.
        if (aw_fire) aw_sent_d = 1'b1;
        if (w_fire)  w_sent_d  = 1'b1;
        if (aw_sent_d && w_sent_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_fire) begin
          rdata_d     = '0;
          resp_d      = m_axi4lite_b_resp;
          rsp_write_d = write_q;
          state_d     = RSP;
          if (m_axi4lite_b_resp != 2'b00) err_d = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_fire) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_fire) begin
          rdata_d     = m_axi4lite_r_data;
          resp_d      = m_axi4lite_r_resp;
          rsp_write_d = write_q;
          state_d     = RSP;
          if (m_axi4lite_r_resp != 2'b00) err_d = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      aw_sent_q   <= 1'b0;
      w_sent_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      rsp_write_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_sent_q   <= aw_sent_d;
      w_sent_q    <= w_sent_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      rsp_write_q <= rsp_write_d;
      err_q       <= err_d;
      if (req_fire) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        write_q <= req_write;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - self-checking bench for axi4_lite_master
`timescale 1ns/1ps
module tb_axi4_lite_master;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 0, rsp_write, err_sticky;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready = 0, w_valid, w_ready = 0, b_valid = 0, b_ready;
  logic        ar_valid, ar_ready = 0, r_valid = 0, r_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_prot, ar_prot;
  logic [63:0] w_data, r_data = '0;
  logic [7:0]  w_strb;
  logic [1:0]  b_resp = 0, r_resp = 0;

  axi4_lite_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_sticky(err_sticky),
    .m_axi4lite_aw_valid(aw_valid), .m_axi4lite_aw_ready(aw_ready),
    .m_axi4lite_aw_addr(aw_addr), .m_axi4lite_aw_prot(aw_prot),
    .m_axi4lite_w_valid(w_valid), .m_axi4lite_w_ready(w_ready),
    .m_axi4lite_w_data(w_data), .m_axi4lite_w_strb(w_strb),
    .m_axi4lite_b_valid(b_valid), .m_axi4lite_b_ready(b_ready), .m_axi4lite_b_resp(b_resp),
    .m_axi4lite_ar_valid(ar_valid), .m_axi4lite_ar_ready(ar_ready),
    .m_axi4lite_ar_addr(ar_addr), .m_axi4lite_ar_prot(ar_prot),
    .m_axi4lite_r_valid(r_valid), .m_axi4lite_r_ready(r_ready),
    .m_axi4lite_r_data(r_data), .m_axi4lite_r_resp(r_resp)
  );

  typedef struct packed {
    logic        w;
    logic [63:0] d;
    logic [1:0]  r;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  bit   auto_slave = 0;

  // Response scoreboard and channel-exclusivity monitor, sampled 1ns after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rsp_valid && rsp_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected got w=%0b d=%h r=%0d required=none", rsp_write, rsp_rdata, rsp_resp);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({rsp_write, rsp_rdata, rsp_resp} !== mon_exp) begin
          miscompares++;
          $display("FAIL rsp_payload got w=%0b d=%h r=%0d required w=%0b d=%h r=%0d",
                   rsp_write, rsp_rdata, rsp_resp, mon_exp.w, mon_exp.d, mon_exp.r);
        end
      end
    end
    if (auto_slave) begin
      vectors++;
      if ((aw_valid | w_valid | b_ready) & (ar_valid | r_ready)) begin
        miscompares++;
        $display("FAIL channel_overlap got wr=%0b%0b%0b rd=%0b%0b required no overlap",
                 aw_valid, w_valid, b_ready, ar_valid, r_ready);
      end
    end
  end

  // Random-ready slave; read data is derived from the address so the bench can predict it.
  always @(negedge clk) begin
    if (auto_slave) begin
      aw_ready  = 1'($urandom_range(0, 1));
      w_ready   = 1'($urandom_range(0, 1));
      ar_ready  = 1'($urandom_range(0, 1));
      b_valid   = 1'($urandom_range(0, 1));
      r_valid   = 1'($urandom_range(0, 1));
      b_resp    = 2'b00;
      r_resp    = 2'b00;
      r_data    = {~ar_addr, ar_addr};
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_req(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_accept_timeout got req_ready=%0b required=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_held got %b required 0000000",
               {req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid});
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_rdata !== 64'h0 || rsp_write !== 1'b0 || rsp_resp !== 2'b00 || err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%0b d=%h w=%0b r=%0d err=%0b required 1,0,0,0,0",
               req_ready, rsp_rdata, rsp_write, rsp_resp, err_sticky);
    end
  endtask

  task automatic test_write_zero_wait();
    aw_ready = 1; w_ready = 1; rsp_ready = 1;
    sb_q.push_back({1'b1, 64'h0, 2'b00});
    send_req(1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    vectors++;
    if ({aw_valid, w_valid, b_ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL wr_c1_valids got %b required 110", {aw_valid, w_valid, b_ready});
    end
    vectors++;
    if (aw_addr !== 32'h100 || w_data !== 64'hDEADBEEF_CAFEF00D || w_strb !== 8'hFF || aw_prot !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_c1_payload got a=%h d=%h s=%h p=%0d required 100,deadbeefcafef00d,ff,0",
               aw_addr, w_data, w_strb, aw_prot);
    end
    @(negedge clk);
    vectors++;
    if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL wr_c2_valids got %b required 001", {aw_valid, w_valid, b_ready});
    end
    b_valid = 1; b_resp = 2'b00;
    @(negedge clk);
    b_valid = 0; aw_ready = 0; w_ready = 0;
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_c3_rsp_valid got %0b required 1", rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_c4_idle got rdy=%0b rv=%0b required 1,0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_skewed_write();
    aw_ready = 0; w_ready = 1; rsp_ready = 1;
    sb_q.push_back({1'b1, 64'h0, 2'b00});
    send_req(1'b1, 32'h180, 64'h1111_2222_3333_4444, 8'h0F);
    vectors++;
    if ({aw_valid, w_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL skew_c1 got %b required 11", {aw_valid, w_valid});
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({aw_valid, w_valid, b_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL skew_c%0d got %b required 100", c, {aw_valid, w_valid, b_ready});
      end
    end
    aw_ready = 1;
    @(negedge clk);
    aw_ready = 0; w_ready = 0;
    vectors++;
    if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL skew_c5 got %b required 001", {aw_valid, w_valid, b_ready});
    end
    b_valid = 1;
    @(negedge clk);
    b_valid = 0;
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL skew_c6_rsp got %0b required 1", rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_read_error();
    ar_ready = 1; rsp_ready = 1;
    sb_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF, 2'b10});
    send_req(1'b0, 32'h200, 64'h0, 8'h0);
    vectors++;
    if (ar_valid !== 1'b1 || ar_addr !== 32'h200 || aw_valid !== 1'b0 || w_valid !== 1'b0 || r_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_c1 got arv=%0b a=%h awv=%0b wv=%0b rr=%0b required 1,200,0,0,0",
               ar_valid, ar_addr, aw_valid, w_valid, r_ready);
    end
    @(negedge clk);
    ar_ready = 0;
    vectors++;
    if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_c2 got arv=%0b rr=%0b required 0,1", ar_valid, r_ready);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    r_valid = 1; r_data = 64'h0123_4567_89AB_CDEF; r_resp = 2'b10;
    @(negedge clk);
    r_valid = 0; r_resp = 2'b00;
    vectors++;
    if (rsp_valid !== 1'b1 || err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_err_rsp got rv=%0b err=%0b required 1,1", rsp_valid, err_sticky);
    end
    @(negedge clk);
    aw_ready = 1; w_ready = 1;
    sb_q.push_back({1'b1, 64'h0, 2'b00});
    send_req(1'b1, 32'h208, 64'h5, 8'h01);
    b_valid = 1; b_resp = 2'b00;
    @(negedge clk); @(negedge clk);
    b_valid = 0; aw_ready = 0; w_ready = 0;
    @(negedge clk);
    vectors++;
    if (err_sticky !== 1'b1 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky_hold got err=%0b rdy=%0b required 1,1", err_sticky, req_ready);
    end
  endtask

  task automatic test_backpressure();
    ar_ready = 1; rsp_ready = 0;
    sb_q.push_back({1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00});
    send_req(1'b0, 32'h300, 64'h0, 8'h0);
    r_valid = 1; r_data = 64'hA5A5_5A5A_0F0F_F0F0; r_resp = 2'b00;
    vectors++;
    if (r_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_c1_r_ready got %0b required 0", r_ready);
    end
    @(negedge clk);
    @(negedge clk);
    r_valid = 0; ar_ready = 0; r_data = '0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hA5A5_5A5A_0F0F_F0F0 || rsp_resp !== 2'b00 ||
          rsp_write !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got rv=%0b d=%h r=%0d w=%0b rdy=%0b required 1,a5a55a5a0f0ff0f0,0,0,0",
                 k, rsp_valid, rsp_rdata, rsp_resp, rsp_write, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got rv=%0b rdy=%0b required 0,1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    aw_ready = 1; w_ready = 1; rsp_ready = 1;
    send_req(1'b1, 32'h400, 64'h77, 8'h03);
    @(negedge clk);
    vectors++;
    if (b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_in_wr_resp got b_ready=%0b required 1", b_ready);
    end
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, req_ready, err_sticky} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_mid_cleared got %b required 00000000",
               {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, req_ready, err_sticky});
    end
    rstn = 1'b1; aw_ready = 0; w_ready = 0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || aw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_release got rdy=%0b rv=%0b awv=%0b required 1,0,0", req_ready, rsp_valid, aw_valid);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_spurious_b();
    ar_ready = 1; rsp_ready = 1; b_valid = 1; b_resp = 2'b10;
    sb_q.push_back({1'b0, 64'hFEED_0000_BEEF_1234, 2'b00});
    send_req(1'b0, 32'h500, 64'h0, 8'h0);
    vectors++;
    if (b_ready !== 1'b0 || ar_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_c1 got br=%0b arv=%0b required 0,1", b_ready, ar_valid);
    end
    @(negedge clk);
    ar_ready = 0;
    r_valid = 1; r_data = 64'hFEED_0000_BEEF_1234; r_resp = 2'b00;
    vectors++;
    if (b_ready !== 1'b0 || r_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_c2 got br=%0b rr=%0b required 0,1", b_ready, r_ready);
    end
    @(negedge clk);
    r_valid = 0;
    vectors++;
    if (b_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_c3 got br=%0b rv=%0b required 0,1", b_ready, rsp_valid);
    end
    @(negedge clk);
    b_valid = 0; b_resp = 2'b00;
    vectors++;
    if (err_sticky !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_done got err=%0b rdy=%0b required 0,1", err_sticky, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic        w;
    logic [31:0] a;
    logic [63:0] d;
    int          n;
    auto_slave = 1;
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF_FFF8;
      d = {$urandom, $urandom};
      sb_q.push_back(w ? {1'b1, 64'h0, 2'b00} : {1'b0, ~a, a, 2'b00});
      send_req(w, a, d, 8'($urandom_range(0, 255)));
    end
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain got %0d pending required 0", sb_q.size());
    end
    auto_slave = 0;
    @(negedge clk);
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0; rsp_ready = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_skewed_write();
    test_read_error();
    test_backpressure();
    test_reset_mid();
    test_spurious_b();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
